ps2_key_rx: RTL and testbench

Host-side PS/2 keyboard receiver. Decodes the raw open-drain PS/2 clock/data pair into the 11-bit toggle-format `ps2_key` event word consumed by the arcade cores' keyboard input logic, where bit 10 toggles per event, bit 9 is pressed, bit 8 is extended and bits 7:0 are the scan code. It is the producing end of that event interface and lets a core take a keyboard directly on a user-port pin pair instead of through hps_io.

---
 rtl/ps2_key_rx.sv | 152 +++++++++++++++
 tb/tb_ps2_key_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// Host-side PS/2 keyboard receiver: conditions the raw clock/data pair, frames
// 11-bit PS/2 bytes and turns scan-code sequences into toggle-format key events.
module ps2_key_rx #(
    parameter int FILTER  = 16,
    parameter int TIMEOUT = 80000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err,
    output logic [1:0]  dbg_state
);
    localparam int FLT_W = $clog2(FILTER + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // Handshake: none. ps2_key is level-held; key_strobe and frame_err are
    // single-cycle pulses, and a change of ps2_key[10] marks a new event.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             flt_clk_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             edge_w;

    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic             ext_q, rel_q;
    logic [2:0]       skip_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [10:0]      key_q;
    logic             strobe_q, err_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            flt_clk_q <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            if (clk_s2_q != flt_clk_q) begin
                if (flt_cnt_q == FLT_W'(FILTER - 1)) begin
                    flt_clk_q <= clk_s2_q;
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 1'b1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    // The edge is the cycle in which the filtered clock commits to low.
    assign edge_w = flt_clk_q & ~clk_s2_q & (flt_cnt_q == FLT_W'(FILTER - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            skip_q    <= '0;
            to_cnt_q  <= '0;
            key_q     <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            if (edge_w) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!((^shift_q ^ par_q) && dat_s2_q)) begin
                            err_q <= 1'b1;
                        end else if (skip_q != 3'd0) begin
                            skip_q <= skip_q - 3'd1;
                        end else if (shift_q == 8'hE1) begin
                            // Pause has no break code; swallow its remaining 7 bytes.
                            skip_q <= 3'd7;
                            ext_q  <= 1'b0;
                            rel_q  <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_q <= 1'b1;
                        end else if (shift_q == 8'h00 || shift_q == 8'hAA ||
                                     shift_q == 8'hEE || shift_q == 8'hFA ||
                                     shift_q == 8'hFE || shift_q == 8'hFF) begin
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                        end else begin
                            key_q    <= {~key_q[10], ~rel_q, ext_q, shift_q};
                            strobe_q <= 1'b1;
                            ext_q    <= 1'b0;
                            rel_q    <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                to_cnt_q <= '0;
                state_q  <= ST_IDLE;
                err_q    <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign ps2_key    = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = err_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: bit-level PS/2 driver, pulse monitors and
// hand-computed expected event words.
module tb_ps2_key_rx;
  localparam int FILTER  = 16;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 30;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_ferr = 0;
  int n_wide = 0;
  logic prev_strobe = 1'b0;
  logic prev_ferr = 1'b0;
  int s0, e0;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  // pulse monitors, sampled away from the active edge
  always @(negedge clk_sys) begin
    if (key_strobe) n_strobe++;
    if (frame_err) n_ferr++;
    if ((key_strobe && prev_strobe) || (frame_err && prev_ferr)) n_wide++;
    prev_strobe = key_strobe;
    prev_ferr = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    idle(gap);
  endtask

  task automatic mark;
    s0 = n_strobe;
    e0 = n_ferr;
  endtask

  initial begin
    idle(4);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_strobe", 32'(key_strobe), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    idle(10);
    check("reset_state", 32'(dbg_state), 32'h0);

    mark();
    send_frame(8'h1C, 1'b0, HALF);
    check("make_1c_key", 32'(ps2_key), 32'h61C);
    check("make_1c_strobes", 32'(n_strobe - s0), 32'd1);

    mark();
    send_frame(8'hF0, 1'b0, HALF);
    check("f0_no_change", 32'(ps2_key), 32'h61C);
    send_frame(8'h1C, 1'b0, HALF);
    check("break_1c_key", 32'(ps2_key), 32'h01C);
    check("break_1c_strobes", 32'(n_strobe - s0), 32'd1);

    mark();
    send_frame(8'hE0, 1'b0, HALF);
    send_frame(8'h75, 1'b0, HALF);
    check("ext_make_key", 32'(ps2_key), 32'h775);
    send_frame(8'hE0, 1'b0, HALF);
    send_frame(8'hF0, 1'b0, HALF);
    send_frame(8'h75, 1'b0, HALF);
    check("ext_break_key", 32'(ps2_key), 32'h175);
    check("ext_strobes", 32'(n_strobe - s0), 32'd2);

    mark();
    send_frame(8'h1C, 1'b1, HALF);
    check("badpar_ferr", 32'(n_ferr - e0), 32'd1);
    check("badpar_strobes", 32'(n_strobe - s0), 32'd0);
    check("badpar_key", 32'(ps2_key), 32'h175);
    send_frame(8'h1C, 1'b0, HALF);
    check("after_badpar_key", 32'(ps2_key), 32'h61C);

    // partial frame then silence
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("partial_state", 32'(dbg_state), 32'h1);
    ps2_data = 1'b1;
    idle(TIMEOUT + 10);
    check("timeout_ferr", 32'(n_ferr - e0), 32'd1);
    check("timeout_state", 32'(dbg_state), 32'h0);
    check("timeout_strobes", 32'(n_strobe - s0), 32'd0);
    send_frame(8'h29, 1'b0, HALF);
    check("after_timeout_key", 32'(ps2_key), 32'h229);

    mark();
    send_frame(8'hE1, 1'b0, HALF);
    send_frame(8'h14, 1'b0, HALF);
    send_frame(8'h77, 1'b0, HALF);
    send_frame(8'hE1, 1'b0, HALF);
    send_frame(8'hF0, 1'b0, HALF);
    send_frame(8'h14, 1'b0, HALF);
    send_frame(8'hF0, 1'b0, HALF);
    send_frame(8'h77, 1'b0, HALF);
    check("pause_strobes", 32'(n_strobe - s0), 32'd0);
    check("pause_key", 32'(ps2_key), 32'h229);
    send_frame(8'h1C, 1'b0, HALF);
    check("after_pause_key", 32'(ps2_key), 32'h61C);

    mark();
    send_frame(8'hFA, 1'b0, HALF);
    check("ack_ignored_key", 32'(ps2_key), 32'h61C);
    check("ack_ignored_strobes", 32'(n_strobe - s0), 32'd0);

    // zero-gap back-to-back frames
    mark();
    send_frame(8'h15, 1'b0, 0);
    check("b2b_first_key", 32'(ps2_key), 32'h215);
    send_frame(8'h16, 1'b0, HALF);
    check("b2b_second_key", 32'(ps2_key), 32'h616);
    check("b2b_strobes", 32'(n_strobe - s0), 32'd2);

    mark();
    ps2_clk = 1'b0;
    idle(FILTER - 2);
    ps2_clk = 1'b1;
    idle(3 * FILTER);
    check("glitch_state", 32'(dbg_state), 32'h0);
    check("glitch_pulses", 32'(n_strobe - s0 + n_ferr - e0), 32'd0);
    send_frame(8'h1C, 1'b0, HALF);
    check("after_glitch_key", 32'(ps2_key), 32'h21C);

    // reset mid-frame with an E0 prefix pending
    send_frame(8'hE0, 1'b0, HALF);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    ps2_data = 1'b1;
    idle(2);
    reset_n = 1'b0;
    idle(3);
    check("midreset_key", 32'(ps2_key), 32'h000);
    check("midreset_strobe", 32'(key_strobe), 32'h0);
    check("midreset_ferr", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    mark();
    idle(TIMEOUT + 10);
    check("midreset_state", 32'(dbg_state), 32'h0);
    check("midreset_no_ferr", 32'(n_ferr - e0), 32'd0);
    send_frame(8'h1C, 1'b0, HALF);
    check("after_reset_key", 32'(ps2_key), 32'h61C);
    check("after_reset_strobes", 32'(n_strobe - s0), 32'd1);

    check("pulse_width", 32'(n_wide), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
